// File: rtl/geri_yazma_birimi.sv
// Writeback stage: merges execute, load and divide results onto the register
// file write port, holding long-latency results and tracking their busy dests.
module geri_yazma_birimi #(
  parameter int VERI_BIT   = 32,
  parameter int ADRES_BIT  = 5,
  parameter int YAS_SINIRI = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 yurut_gecerli_i,
  input  logic [ADRES_BIT-1:0] yurut_adres_i,
  input  logic [VERI_BIT-1:0]  yurut_deger_i,
  output logic                 durdur_o,
  input  logic                 bellek_gecerli_i,
  input  logic [ADRES_BIT-1:0] bellek_adres_i,
  input  logic [VERI_BIT-1:0]  bellek_deger_i,
  output logic                 bellek_hazir_o,
  input  logic                 bolme_gecerli_i,
  input  logic [ADRES_BIT-1:0] bolme_adres_i,
  input  logic [VERI_BIT-1:0]  bolme_deger_i,
  output logic                 bolme_hazir_o,
  input  logic                 ayrim_gecerli_i,
  input  logic [ADRES_BIT-1:0] ayrim_adres_i,
  input  logic [ADRES_BIT-1:0] ky1_adres_i,
  input  logic [ADRES_BIT-1:0] ky2_adres_i,
  output logic                 ky1_mesgul_o,
  output logic                 ky2_mesgul_o,
  output logic                 yaz_o,
  output logic [ADRES_BIT-1:0] hy_adres_o,
  output logic [VERI_BIT-1:0]  hy_deger_o
);

  localparam int REG_SAYISI = 1 << ADRES_BIT;
  localparam logic [1:0] YAS_ESIK = 2'(YAS_SINIRI);

  typedef enum logic [1:0] {SEC_YOK, SEC_BL, SEC_BO, SEC_YU} sec_e;

  logic                  r_bl_dolu, r_bo_dolu;
  logic [1:0]            r_bl_yas, r_bo_yas;
  logic [ADRES_BIT-1:0]  r_bl_adres, r_bo_adres;
  logic [VERI_BIT-1:0]   r_bl_deger, r_bo_deger;
  logic                  r_yaz, r_uzun;
  logic [ADRES_BIT-1:0]  r_hy_adres;
  logic [VERI_BIT-1:0]   r_hy_deger;
  logic [REG_SAYISI-1:0] r_mesgul;

  logic                  w_bl_yasli, w_bo_yasli, w_durdur;
  sec_e                  w_sec;
  logic [ADRES_BIT-1:0]  w_sec_adres;
  logic [VERI_BIT-1:0]   w_sec_deger;
  logic [REG_SAYISI-1:0] w_mesgul_sonraki;

  assign w_bl_yasli = r_bl_dolu && (r_bl_yas >= YAS_ESIK);
  assign w_bo_yasli = r_bo_dolu && (r_bo_yas >= YAS_ESIK);
  assign w_durdur   = w_bl_yasli || w_bo_yasli;

  always_comb begin
    w_sec       = SEC_YOK;
    w_sec_adres = '0;
    w_sec_deger = '0;
    if (w_bl_yasli)                       w_sec = SEC_BL;
    else if (w_bo_yasli)                  w_sec = SEC_BO;
    else if (yurut_gecerli_i && !w_durdur) w_sec = SEC_YU;
    else if (r_bl_dolu)                   w_sec = SEC_BL;
    else if (r_bo_dolu)                   w_sec = SEC_BO;
    case (w_sec)
      SEC_BL:  begin w_sec_adres = r_bl_adres;    w_sec_deger = r_bl_deger;    end
      SEC_BO:  begin w_sec_adres = r_bo_adres;    w_sec_deger = r_bo_deger;    end
      SEC_YU:  begin w_sec_adres = yurut_adres_i; w_sec_deger = yurut_deger_i; end
      default: ;
    endcase
  end

  // Set is applied after clear so a reissue to the retiring register stays busy.
  always_comb begin
    w_mesgul_sonraki = r_mesgul;
    if (r_yaz && r_uzun)
      w_mesgul_sonraki[r_hy_adres] = 1'b0;
    if (ayrim_gecerli_i && (ayrim_adres_i != '0))
      w_mesgul_sonraki[ayrim_adres_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bl_dolu  <= 1'b0;
      r_bl_yas   <= '0;
      r_bl_adres <= '0;
      r_bl_deger <= '0;
      r_bo_dolu  <= 1'b0;
      r_bo_yas   <= '0;
      r_bo_adres <= '0;
      r_bo_deger <= '0;
      r_yaz      <= 1'b0;
      r_uzun     <= 1'b0;
      r_hy_adres <= '0;
      r_hy_deger <= '0;
      r_mesgul   <= '0;
    end else begin
      r_mesgul <= w_mesgul_sonraki;

      if (w_sec == SEC_BL) begin
        r_bl_dolu <= 1'b0;
        r_bl_yas  <= '0;
      end else if (!r_bl_dolu && bellek_gecerli_i) begin
        r_bl_dolu  <= 1'b1;
        r_bl_yas   <= '0;
        r_bl_adres <= bellek_adres_i;
        r_bl_deger <= bellek_deger_i;
      end else if (r_bl_dolu && (r_bl_yas != 2'd3)) begin
        r_bl_yas <= r_bl_yas + 2'd1;
      end

      if (w_sec == SEC_BO) begin
        r_bo_dolu <= 1'b0;
        r_bo_yas  <= '0;
      end else if (!r_bo_dolu && bolme_gecerli_i) begin
        r_bo_dolu  <= 1'b1;
        r_bo_yas   <= '0;
        r_bo_adres <= bolme_adres_i;
        r_bo_deger <= bolme_deger_i;
      end else if (r_bo_dolu && (r_bo_yas != 2'd3)) begin
        r_bo_yas <= r_bo_yas + 2'd1;
      end

      // x0 results are consumed but never raise the write enable.
      if (w_sec != SEC_YOK) begin
        r_hy_adres <= w_sec_adres;
        r_hy_deger <= w_sec_deger;
        r_yaz      <= (w_sec_adres != '0);
        r_uzun     <= (w_sec != SEC_YU);
      end else begin
        r_yaz  <= 1'b0;
        r_uzun <= 1'b0;
      end
    end
  end

  assign durdur_o       = w_durdur;
  assign bellek_hazir_o = ~r_bl_dolu & ~rst_i;
  assign bolme_hazir_o  = ~r_bo_dolu & ~rst_i;
  assign ky1_mesgul_o   = (ky1_adres_i != '0) && r_mesgul[ky1_adres_i];
  assign ky2_mesgul_o   = (ky2_adres_i != '0) && r_mesgul[ky2_adres_i];
  assign yaz_o          = r_yaz;
  assign hy_adres_o     = r_hy_adres;
  assign hy_deger_o     = r_hy_deger;

endmodule

// File: tb/tb_geri_yazma_birimi.sv
// Bench for geri_yazma_birimi: directed scenarios plus a random run against a
// cycle-level reference of the merge, aging and scoreboard rules.
module tb_geri_yazma_birimi;

  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        yv, bg, dg, ag;
  logic [4:0]  ya, ba, da, aa, k1, k2;
  logic [31:0] yd, bd, dd;
  logic        durdur, bh, dh, m1, m2, yaz;
  logic [4:0]  hadr;
  logic [31:0] hdat;

  int checks = 0;
  int errors = 0;

  // reference state
  bit        m_ld_full, m_dv_full, m_yaz, m_long, m_ex_hold;
  int        m_ld_age, m_dv_age;
  bit [4:0]  m_ld_a, m_dv_a, m_adr;
  bit [31:0] m_ld_d, m_dv_d, m_dat, m_busy;

  always #5 clk = ~clk;

  geri_yazma_birimi #(.VERI_BIT(32), .ADRES_BIT(5), .YAS_SINIRI(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .yurut_gecerli_i(yv), .yurut_adres_i(ya), .yurut_deger_i(yd), .durdur_o(durdur),
    .bellek_gecerli_i(bg), .bellek_adres_i(ba), .bellek_deger_i(bd), .bellek_hazir_o(bh),
    .bolme_gecerli_i(dg), .bolme_adres_i(da), .bolme_deger_i(dd), .bolme_hazir_o(dh),
    .ayrim_gecerli_i(ag), .ayrim_adres_i(aa),
    .ky1_adres_i(k1), .ky2_adres_i(k2), .ky1_mesgul_o(m1), .ky2_mesgul_o(m2),
    .yaz_o(yaz), .hy_adres_o(hadr), .hy_deger_o(hdat)
  );

  function automatic bit m_durdur();
    return (m_ld_age >= LIMIT) || (m_dv_age >= LIMIT);
  endfunction

  function automatic bit m_busy_of(input bit [4:0] a);
    return (a != 0) && m_busy[a];
  endfunction

  task automatic model_reset();
    m_ld_full = 0; m_dv_full = 0; m_ld_age = 0; m_dv_age = 0;
    m_yaz = 0; m_long = 0; m_adr = 0; m_dat = 0; m_busy = 0; m_ex_hold = 0;
  endtask

  // Advance the reference by one clock edge using the inputs now applied.
  task automatic model_step();
    int win;
    bit dur;
    dur = m_durdur();
    if (m_ld_full && m_ld_age >= LIMIT)      win = 1;
    else if (m_dv_full && m_dv_age >= LIMIT) win = 2;
    else if (yv && !dur)                     win = 3;
    else if (m_ld_full)                      win = 1;
    else if (m_dv_full)                      win = 2;
    else                                     win = 0;
    m_ex_hold = yv && dur;
    if (m_yaz && m_long) m_busy[m_adr] = 1'b0;
    if (ag && aa != 0)   m_busy[aa] = 1'b1;
    case (win)
      1: begin m_adr = m_ld_a; m_dat = m_ld_d; m_long = 1; end
      2: begin m_adr = m_dv_a; m_dat = m_dv_d; m_long = 1; end
      3: begin m_adr = ya;     m_dat = yd;     m_long = 0; end
      default: m_long = 0;
    endcase
    m_yaz = (win != 0) && (m_adr != 0);
    if (win == 1) begin m_ld_full = 0; m_ld_age = 0; end
    else if (!m_ld_full && bg) begin m_ld_full = 1; m_ld_age = 0; m_ld_a = ba; m_ld_d = bd; end
    else if (m_ld_full && m_ld_age < 3) m_ld_age++;
    if (win == 2) begin m_dv_full = 0; m_dv_age = 0; end
    else if (!m_dv_full && dg) begin m_dv_full = 1; m_dv_age = 0; m_dv_a = da; m_dv_d = dd; end
    else if (m_dv_full && m_dv_age < 3) m_dv_age++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    yv = 0; bg = 0; dg = 0; ag = 0;
    ya = 0; ba = 0; da = 0; aa = 0; yd = 0; bd = 0; dd = 0;
  endtask

  task automatic test_reset();
    idle(); k1 = 0; k2 = 0;
    rst = 1;
    #1;
    checks++;
    if ({yaz, hadr, hdat} !== 38'd0) begin
      errors++; $display("FAIL reset_out: got yaz=%b adr=%0d dat=%h want 0/0/0", yaz, hadr, hdat);
    end
    checks++;
    if ({bh, dh} !== 2'b00) begin
      errors++; $display("FAIL reset_hazir: got %b%b want 00", bh, dh);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    #1;
    checks++;
    if ({bh, dh, durdur} !== 3'b110) begin
      errors++; $display("FAIL reset_release: got bh=%b dh=%b durdur=%b want 1 1 0", bh, dh, durdur);
    end
  endtask

  task automatic test_execute();
    yv = 1; ya = 5; yd = 32'hDEADBEEF;
    #1;
    checks++;
    if (durdur !== 1'b0) begin errors++; $display("FAIL exec_durdur: got %b want 0", durdur); end
    tick(); idle();
    checks++;
    if ({yaz, hadr, hdat} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL exec_write: got yaz=%b adr=%0d dat=%h want 1/5/deadbeef", yaz, hadr, hdat);
    end
    tick();
    checks++;
    if (yaz !== 1'b0) begin errors++; $display("FAIL exec_single: got yaz=%b want 0", yaz); end
  endtask

  task automatic test_load_busy();
    ag = 1; aa = 7; k1 = 7;
    tick(); idle();
    checks++;
    if (m1 !== 1'b1) begin errors++; $display("FAIL ld_busy_set: got %b want 1", m1); end
    bg = 1; ba = 7; bd = 32'h11;
    tick(); idle();
    checks++;
    if ({bh, yaz, m1} !== 3'b001) begin
      errors++; $display("FAIL ld_held: got bh=%b yaz=%b busy=%b want 0 0 1", bh, yaz, m1);
    end
    tick();
    checks++;
    if ({yaz, hadr, hdat, m1} !== {1'b1, 5'd7, 32'h11, 1'b1}) begin
      errors++; $display("FAIL ld_write: got yaz=%b adr=%0d dat=%h busy=%b want 1/7/11/1", yaz, hadr, hdat, m1);
    end
    tick();
    checks++;
    if ({yaz, m1, bh} !== 3'b001) begin
      errors++; $display("FAIL ld_busy_clear: got yaz=%b busy=%b bh=%b want 0 0 1", yaz, m1, bh);
    end
    k1 = 0;
  endtask

  task automatic test_aging();
    bg = 1; ba = 9; bd = 32'h99; yv = 1; ya = 3; yd = 32'h30;
    tick(); bg = 0; ba = 0; bd = 0;
    ya = 4; yd = 32'h40;
    tick();
    ya = 5; yd = 32'h50;
    #1;
    checks++;
    if ({durdur, yaz, hadr} !== {1'b0, 1'b1, 5'd4}) begin
      errors++; $display("FAIL age_wait: got durdur=%b yaz=%b adr=%0d want 0 1 4", durdur, yaz, hadr);
    end
    tick();
    ya = 6; yd = 32'h60;
    #1;
    checks++;
    if (durdur !== 1'b1) begin errors++; $display("FAIL age_durdur: got %b want 1", durdur); end
    tick();
    checks++;
    if ({durdur, yaz, hadr, hdat} !== {1'b0, 1'b1, 5'd9, 32'h99}) begin
      errors++; $display("FAIL age_load_write: got durdur=%b yaz=%b adr=%0d dat=%h want 0 1 9 99", durdur, yaz, hadr, hdat);
    end
    tick(); idle();
    checks++;
    if ({yaz, hadr, hdat} !== {1'b1, 5'd6, 32'h60}) begin
      errors++; $display("FAIL age_held_exec: got yaz=%b adr=%0d dat=%h want 1 6 60", yaz, hadr, hdat);
    end
    tick();
  endtask

  task automatic test_both();
    bg = 1; ba = 10; bd = 32'hA; dg = 1; da = 11; dd = 32'hB;
    tick(); idle();
    checks++;
    if ({bh, dh, yaz} !== 3'b000) begin
      errors++; $display("FAIL both_held: got bh=%b dh=%b yaz=%b want 0 0 0", bh, dh, yaz);
    end
    tick();
    checks++;
    if ({yaz, hadr, hdat, bh, dh} !== {1'b1, 5'd10, 32'hA, 1'b1, 1'b0}) begin
      errors++; $display("FAIL both_load_first: got yaz=%b adr=%0d dat=%h bh=%b dh=%b want 1 10 a 1 0", yaz, hadr, hdat, bh, dh);
    end
    tick();
    checks++;
    if ({yaz, hadr, hdat, dh} !== {1'b1, 5'd11, 32'hB, 1'b1}) begin
      errors++; $display("FAIL both_div_second: got yaz=%b adr=%0d dat=%h dh=%b want 1 11 b 1", yaz, hadr, hdat, dh);
    end
    tick();
  endtask

  task automatic test_x0();
    yv = 1; ya = 0; yd = 32'hFFFFFFFF;
    tick(); idle();
    checks++;
    if ({yaz, durdur} !== 2'b00) begin
      errors++; $display("FAIL x0_exec: got yaz=%b durdur=%b want 0 0", yaz, durdur);
    end
    ag = 1; aa = 0; k1 = 0; k2 = 0;
    tick(); idle();
    checks++;
    if ({m1, m2} !== 2'b00) begin errors++; $display("FAIL x0_busy: got %b%b want 00", m1, m2); end
  endtask

  task automatic test_reset_mid();
    ag = 1; aa = 12; k1 = 12; k2 = 12;
    tick(); idle();
    bg = 1; ba = 12; bd = 32'h12; yv = 1; ya = 2; yd = 32'h22;
    tick(); idle();
    checks++;
    if ({yaz, bh, m1} !== 3'b101) begin
      errors++; $display("FAIL mid_before: got yaz=%b bh=%b busy=%b want 1 0 1", yaz, bh, m1);
    end
    #2 rst = 1;
    #1;
    checks++;
    if ({yaz, bh, dh, m1, m2} !== 5'b00000) begin
      errors++; $display("FAIL mid_reset: got yaz=%b bh=%b dh=%b busy=%b%b want all 0", yaz, bh, dh, m1, m2);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    #1;
    checks++;
    if ({bh, dh} !== 2'b11) begin errors++; $display("FAIL mid_release: got %b%b want 11", bh, dh); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({yaz, m1} !== 2'b00) begin
        errors++; $display("FAIL mid_stale: cycle %0d got yaz=%b busy=%b want 0 0", i, yaz, m1);
      end
    end
    k1 = 0; k2 = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (!m_ex_hold) begin
        yv = ($urandom_range(0, 99) < 55);
        ya = 5'($urandom); yd = $urandom;
      end
      bg = ($urandom_range(0, 99) < 30); ba = 5'($urandom); bd = $urandom;
      dg = ($urandom_range(0, 99) < 25); da = 5'($urandom); dd = $urandom;
      ag = ($urandom_range(0, 99) < 30); aa = 5'($urandom);
      k1 = 5'($urandom); k2 = 5'($urandom);
      if ($urandom_range(0, 7) == 0) k1 = aa;
      @(negedge clk);
      checks++;
      if (yaz !== m_yaz || (m_yaz && (hadr !== m_adr || hdat !== m_dat))) begin
        errors++; $display("FAIL rand_write c=%0d: got yaz=%b adr=%0d dat=%h want %b %0d %h", c, yaz, hadr, hdat, m_yaz, m_adr, m_dat);
      end
      checks++;
      if ({durdur, bh, dh} !== {m_durdur(), !m_ld_full, !m_dv_full}) begin
        errors++; $display("FAIL rand_ctrl c=%0d: got durdur=%b bh=%b dh=%b want %b %b %b", c, durdur, bh, dh, m_durdur(), !m_ld_full, !m_dv_full);
      end
      checks++;
      if ({m1, m2} !== {m_busy_of(k1), m_busy_of(k2)}) begin
        errors++; $display("FAIL rand_busy c=%0d: got %b%b want %b%b", c, m1, m2, m_busy_of(k1), m_busy_of(k2));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_execute();
    test_load_busy();
    test_aging();
    test_both();
    test_x0();
    test_reset_mid();
    test_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
